// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: a Moore FSM that sequences
// fetch / decode / memory / execute / writeback and drives datapath selects.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       Z_FLAG,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [3:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegWrite,
    output logic       Write_Z_ENABLE,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t state_q, state_d;

    logic       cond_ex;
    logic [3:0] cmd;
    logic       is_cmp;
    logic       rd_is_pc;

    assign cmd      = Funct[4:1];
    assign is_cmp   = (cmd == 4'b1010);
    assign rd_is_pc = (Rd == 4'b1111);

    // Condition evaluation: only EQ, NE and AL are supported, others never execute
    always_comb begin
        case (Cond)
            4'b0000: cond_ex = Z_FLAG;
            4'b0001: cond_ex = ~Z_FLAG;
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Register-address and immediate selects depend only on the instruction fields
    assign RegSrc    = (Op == 2'b10)                 ? 2'b01 :
                       ((Op == 2'b01) && !Funct[0])  ? 2'b10 : 2'b00;
    assign ImmSrc    = Op;
    assign state_out = state_q;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state and per-state outputs; reset masks every write enable
    always_comb begin
        state_d        = FETCH;
        PCWrite        = 1'b0;
        AdrSrc         = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        ResultSrc      = 2'b00;
        ALUControl     = 4'b0000;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'b00;
        RegWrite       = 1'b0;
        Write_Z_ENABLE = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 4'b0100;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 4'b0100;
                ResultSrc  = 2'b10;
                if (!cond_ex)          state_d = FETCH;
                else if (Op == 2'b01)  state_d = MEMADR;
                else if (Op == 2'b10)  state_d = BRANCH;
                else if (Op == 2'b00)  state_d = Funct[5] ? EXECI : EXECR;
                else                   state_d = FETCH;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = 4'b0100;
                state_d    = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                PCWrite   = rd_is_pc;
                RegWrite  = ~rd_is_pc;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcB        = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl     = cmd;
                Write_Z_ENABLE = Funct[0] | is_cmp;
                // CMP only updates flags, so it skips writeback
                state_d        = is_cmp ? FETCH : ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                PCWrite   = rd_is_pc;
                RegWrite  = ~rd_is_pc;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 4'b0100;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (reset) begin
            PCWrite        = 1'b0;
            MemWrite       = 1'b0;
            IRWrite        = 1'b0;
            RegWrite       = 1'b0;
            Write_Z_ENABLE = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each test pushes the expected per-cycle outputs of an
// instruction, then the scoreboard pops and compares one entry per cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       Z_FLAG;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Write_Z_ENABLE;
    logic       ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] ALUControl, state_out;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .Z_FLAG(Z_FLAG), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .RegWrite(RegWrite), .Write_Z_ENABLE(Write_Z_ENABLE), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] wen;   // {PCWrite, MemWrite, IRWrite, RegWrite, Write_Z_ENABLE}
        logic       adr;
        logic [1:0] rsrc;
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] imm;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;
    string tname;
    logic [1:0] cur_rs, cur_imm;

    wire [4:0] wen_o = {PCWrite, MemWrite, IRWrite, RegWrite, Write_Z_ENABLE};
    wire [9:0] mux_o = {AdrSrc, ResultSrc, ALUControl, ALUSrcA, ALUSrcB};

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r, input logic z,
                             input logic [1:0] rs, input logic [1:0] imm);
        Cond = c; Op = o; Funct = f; Rd = r; Z_FLAG = z;
        cur_rs = rs; cur_imm = imm;
    endtask

    task automatic px(input logic [3:0] st, input logic [4:0] wen, input logic adr,
                      input logic [1:0] rsrc, input logic [3:0] alu, input logic sa,
                      input logic [1:0] sb);
        exp_t e;
        e.st = st; e.wen = wen; e.adr = adr; e.rsrc = rsrc; e.alu = alu;
        e.sa = sa; e.sb = sb; e.rs = cur_rs; e.imm = cur_imm;
        q.push_back(e);
    endtask

    task automatic pf(); px(4'd0, 5'b10100, 1'b0, 2'b10, 4'b0100, 1'b1, 2'b10); endtask
    task automatic pd(); px(4'd1, 5'b00000, 1'b0, 2'b10, 4'b0100, 1'b1, 2'b10); endtask

    // Consumer side: called at a falling edge with the DUT in the first expected
    // state; returns at a falling edge one cycle past the last entry.
    task automatic run_scoreboard();
        exp_t e;
        int   cyc = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            #1;
            checks++;
            if (state_out !== e.st) begin
                errors++;
                $display("FAIL %s c%0d state: got %0d want %0d", tname, cyc, state_out, e.st);
            end
            checks++;
            if (wen_o !== e.wen) begin
                errors++;
                $display("FAIL %s c%0d wen: got %b want %b", tname, cyc, wen_o, e.wen);
            end
            checks++;
            if (mux_o !== {e.adr, e.rsrc, e.alu, e.sa, e.sb}) begin
                errors++;
                $display("FAIL %s c%0d mux: got %b want %b", tname, cyc, mux_o,
                         {e.adr, e.rsrc, e.alu, e.sa, e.sb});
            end
            checks++;
            if ({RegSrc, ImmSrc} !== {e.rs, e.imm}) begin
                errors++;
                $display("FAIL %s c%0d regsrc/immsrc: got %b want %b", tname, cyc,
                         {RegSrc, ImmSrc}, {e.rs, e.imm});
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 1'b0, 2'b00, 2'b00);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            checks++;
            if (state_out !== 4'd0) begin
                errors++;
                $display("FAIL reset state: got %0d want 0", state_out);
            end
            checks++;
            if (wen_o !== 5'b00000) begin
                errors++;
                $display("FAIL reset wen: got %b want 00000", wen_o);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        tname = "add_reg";
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 1'b0, 2'b00, 2'b00);
        pf(); pd();
        px(4'd6, 5'b00000, 1'b0, 2'b00, 4'b0100, 1'b0, 2'b00);
        px(4'd8, 5'b00010, 1'b0, 2'b00, 4'b0000, 1'b0, 2'b00);
        run_scoreboard();
        tname = "eors_reg";
        set_instr(4'b1110, 2'b00, 6'b000011, 4'd2, 1'b1, 2'b00, 2'b00);
        pf(); pd();
        px(4'd6, 5'b00001, 1'b0, 2'b00, 4'b0001, 1'b0, 2'b00);
        px(4'd8, 5'b00010, 1'b0, 2'b00, 4'b0000, 1'b0, 2'b00);
        run_scoreboard();
        tname = "mov_imm_pc";
        set_instr(4'b1110, 2'b00, 6'b111010, 4'hF, 1'b0, 2'b00, 2'b00);
        pf(); pd();
        px(4'd7, 5'b00000, 1'b0, 2'b00, 4'b1101, 1'b0, 2'b01);
        px(4'd8, 5'b10000, 1'b0, 2'b00, 4'b0000, 1'b0, 2'b00);
        run_scoreboard();
    endtask

    task automatic test_cmp();
        tname = "cmp_s";
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 1'b0, 2'b00, 2'b00);
        pf(); pd();
        px(4'd6, 5'b00001, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
        run_scoreboard();
        tname = "cmp_imm_nos";
        set_instr(4'b1110, 2'b00, 6'b110100, 4'd3, 1'b0, 2'b00, 2'b00);
        pf(); pd();
        px(4'd7, 5'b00001, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b01);
        run_scoreboard();
    endtask

    task automatic test_load();
        tname = "ldr";
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd4, 1'b0, 2'b00, 2'b01);
        pf(); pd();
        px(4'd2, 5'b00000, 1'b0, 2'b00, 4'b0100, 1'b0, 2'b01);
        px(4'd3, 5'b00000, 1'b1, 2'b00, 4'b0000, 1'b0, 2'b00);
        px(4'd4, 5'b00010, 1'b0, 2'b01, 4'b0000, 1'b0, 2'b00);
        run_scoreboard();
        tname = "ldr_pc";
        set_instr(4'b0000, 2'b01, 6'b011001, 4'hF, 1'b1, 2'b00, 2'b01);
        pf(); pd();
        px(4'd2, 5'b00000, 1'b0, 2'b00, 4'b0100, 1'b0, 2'b01);
        px(4'd3, 5'b00000, 1'b1, 2'b00, 4'b0000, 1'b0, 2'b00);
        px(4'd4, 5'b10000, 1'b0, 2'b01, 4'b0000, 1'b0, 2'b00);
        run_scoreboard();
    endtask

    task automatic test_branch();
        tname = "beq_taken";
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 1'b1, 2'b01, 2'b10);
        pf(); pd();
        px(4'd9, 5'b10000, 1'b0, 2'b10, 4'b0100, 1'b0, 2'b01);
        run_scoreboard();
        tname = "beq_not_taken";
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 1'b0, 2'b01, 2'b10);
        pf(); pd();
        run_scoreboard();
        tname = "bne_taken";
        set_instr(4'b0001, 2'b10, 6'b100000, 4'd0, 1'b0, 2'b01, 2'b10);
        pf(); pd();
        px(4'd9, 5'b10000, 1'b0, 2'b10, 4'b0100, 1'b0, 2'b01);
        run_scoreboard();
    endtask

    task automatic test_cond_fail();
        tname = "add_ne_fail";
        set_instr(4'b0001, 2'b00, 6'b001000, 4'd1, 1'b1, 2'b00, 2'b00);
        pf(); pd();
        run_scoreboard();
        tname = "add_gt_unsupported";
        set_instr(4'b1100, 2'b00, 6'b001000, 4'd1, 1'b0, 2'b00, 2'b00);
        pf(); pd();
        run_scoreboard();
        tname = "op11";
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd5, 1'b0, 2'b00, 2'b11);
        pf(); pd();
        run_scoreboard();
    endtask

    task automatic test_reset_mid_store();
        tname = "str_pre_reset";
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd6, 1'b0, 2'b10, 2'b01);
        pf(); pd();
        px(4'd2, 5'b00000, 1'b0, 2'b00, 4'b0100, 1'b0, 2'b01);
        run_scoreboard();
        // DUT now sits in MEMWR
        reset = 1'b1;
        #1;
        checks++;
        if (state_out !== 4'd5) begin
            errors++;
            $display("FAIL rst_mid state_in_memwr: got %0d want 5", state_out);
        end
        checks++;
        if (wen_o !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid wen_in_memwr: got %b want 00000", wen_o);
        end
        @(negedge clk); #1;
        checks++;
        if (state_out !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid state_after_edge: got %0d want 0", state_out);
        end
        checks++;
        if (wen_o !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid wen_after_edge: got %b want 00000", wen_o);
        end
        reset = 1'b0;
        tname = "str_after_reset";
        pf(); pd();
        px(4'd2, 5'b00000, 1'b0, 2'b00, 4'b0100, 1'b0, 2'b01);
        px(4'd5, 5'b01000, 1'b1, 2'b00, 4'b0000, 1'b0, 2'b00);
        run_scoreboard();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                tname = "b2b_sub";
                set_instr(4'b1110, 2'b00, 6'b000100, 4'(i), 1'b0, 2'b00, 2'b00);
                pf(); pd();
                px(4'd6, 5'b00000, 1'b0, 2'b00, 4'b0010, 1'b0, 2'b00);
                px(4'd8, 5'b00010, 1'b0, 2'b00, 4'b0000, 1'b0, 2'b00);
            end else begin
                tname = "b2b_b";
                set_instr(4'b1110, 2'b10, 6'b100000, 4'd0, 1'b0, 2'b01, 2'b10);
                pf(); pd();
                px(4'd9, 5'b10000, 1'b0, 2'b10, 4'b0100, 1'b0, 2'b01);
            end
            run_scoreboard();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_cmp();
        test_load();
        test_branch();
        test_cond_fail();
        test_reset_mid_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset, with ports named clk and reset.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Cond  in  4  instruction bits [31:28]
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- Rd  in  4  instruction bits [15:12]
- Z_FLAG  in  1  stored zero flag, held in the datapath
- PCWrite  out  1  PC register load
- AdrSrc  out  1  memory address select; 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction register load
- ResultSrc  out  2  result select; 00=ALUOut, 01=Data, 10=ALU direct
- ALUControl  out  4  ALU operation, cmd encoding
- ALUSrcA  out  1  ALU A operand; 0=Rd1, 1=PC
- ALUSrcB  out  2  ALU B operand; 00=Rd2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  immediate extend select, equal to Op
- RegSrc  out  2  register address select
- RegWrite  out  1  register file write
- Write_Z_ENABLE  out  1  Z flag register load
- state_out  out  4  current state code, for debug

Function
REQ-003 The block SHALL be a Moore FSM with these state codes:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
- codes 10-15 unused
REQ-004 The block SHALL compute CondEx as follows:
- Cond=0000 (EQ): CondEx = Z_FLAG
- Cond=0001 (NE): CondEx = !Z_FLAG
- Cond=1110 (AL): CondEx = 1
- all other Cond values: CondEx = 0
REQ-005 FETCH SHALL assert: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=0100, ResultSrc=10, PCWrite=1.
REQ-006 FETCH SHALL always go to DECODE.
REQ-007 DECODE SHALL assert: ALUSrcA=1, ALUSrcB=10, ALUControl=0100, ResultSrc=10; all write enables SHALL be 0.
REQ-008 RegSrc SHALL be 01 when Op=10, SHALL be 10 when Op=01 with Funct[0]=0, and SHALL be 00 otherwise.
REQ-009 DECODE SHALL transition as follows:
- CondEx=0 -> FETCH
- Op=01 -> MEMADR
- Op=10 -> BRANCH
- Op=00 with Funct[5]=1 -> EXECI
- Op=00 with Funct[5]=0 -> EXECR
- Op=11 -> FETCH
REQ-010 MEMADR SHALL assert ALUSrcA=0, ALUSrcB=01, ALUControl=0100, and SHALL go to MEMRD if Funct[0]=1, else to MEMWR.
REQ-011 MEMRD SHALL assert AdrSrc=1 and SHALL go to MEMWB.
REQ-012 MEMWB SHALL assert ResultSrc=01 and SHALL go to FETCH.
REQ-013 MEMWR SHALL assert AdrSrc=1 and MemWrite=1, and SHALL go to FETCH.
REQ-014 EXECR and EXECI SHALL assert ALUSrcA=0 and ALUControl=Funct[4:1], with ALUSrcB=00 in EXECR and 01 in EXECI.
REQ-015 EXECR and EXECI SHALL assert Write_Z_ENABLE when Funct[0]=1 or cmd=1010.
REQ-016 EXECR and EXECI SHALL go to FETCH when cmd=1010 (CMP, no writeback), and to ALUWB otherwise.
REQ-017 ALUWB SHALL assert ResultSrc=00 and SHALL go to FETCH.
REQ-018 In MEMWB and ALUWB, Rd=1111 SHALL assert PCWrite=1 with RegWrite=0; any other Rd SHALL assert RegWrite=1 with PCWrite=0.
REQ-019 BRANCH SHALL assert ALUSrcA=0, ALUSrcB=01, ALUControl=0100, ResultSrc=10, PCWrite=1, and SHALL go to FETCH.
REQ-020 Outputs not listed for a state SHALL be 0.
REQ-021 Instruction latency SHALL be:
- CMP: 3 cycles
- branch: 3 cycles
- store: 4 cycles
- ALU op: 4 cycles
- load: 5 cycles
- condition-failed instruction: 2 cycles
- Op=11: 2 cycles
REQ-022 An unused state code SHALL force all write enables to 0 and SHALL go to FETCH on the next edge.
REQ-023 state_out SHALL equal the state register at all times.

Reset
REQ-024 When reset=1 at a rising edge, the state SHALL become FETCH.
REQ-025 While reset=1, PCWrite, MemWrite, IRWrite, RegWrite and Write_Z_ENABLE SHALL be forced to 0 regardless of state.
REQ-026 A reset asserted mid-instruction SHALL abandon that instruction with no further write enables.
REQ-027 After reset deasserts, the first rising edge SHALL perform a FETCH.

Verification
REQ-028 ADD R1,R2,R3 (Op=00, Funct=001000, Cond=1110, Rd=0001) -> states 0,1,6,8; RegWrite=1 only in state 8; ALUControl=0100 in state 6.
REQ-029 LDR with Funct[0]=1, Rd=0100 -> states 0,1,2,3,4; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4.
REQ-030 BEQ with Z_FLAG=1 -> states 0,1,9 with PCWrite=1 in state 9; with Z_FLAG=0 -> states 0,1,0, with no PCWrite in state 1.
REQ-031 CMP (Funct=010101) -> states 0,1,6,0; Write_Z_ENABLE=1 in state 6; RegWrite never asserted.
REQ-032 MOV-type ALU op with Rd=1111 -> PCWrite=1 and RegWrite=0 in ALUWB.
REQ-033 Reset asserted while in MEMWR -> no MemWrite during reset; state_out=0 after the edge; FETCH on the first cycle after release.
